reg_file: RTL
=============

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 SHALL have parameter ROB_IDX_SIZE, default 4, meaning the tag width (16-entry ROB).
REQ-002 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port rst_in  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port rdy_in  input  1  pause: when low, all state holds.
REQ-005 SHALL have port roll_back  input  1  mispredict flush: clear all pending tags.
REQ-006 SHALL have port rf_in_en  input  1  commit write valid, from ROB.
REQ-007 SHALL have port rf_rob_idx_in  input  ROB_IDX_SIZE  ROB index of the committing entry.
REQ-008 SHALL have port rf_dest_in  input  5  architectural destination of the commit.
REQ-009 SHALL have port rf_val_in  input  32  commit data.
REQ-010 SHALL have port de_rename_en  input  1  decoder allocates a ROB entry that writes a register.
REQ-011 SHALL have port de_rd_in  input  5  destination register of the dispatched instruction.
REQ-012 SHALL have port de_rob_idx_in  input  ROB_IDX_SIZE  ROB index allocated to it.
REQ-013 SHALL have ports rs1_in and rs2_in  input  5 each  source register indices.
REQ-014 SHALL have ports rs1_val_out and rs2_val_out  output  32 each  architectural value.
REQ-015 SHALL have ports rs1_busy_out and rs2_busy_out  output  1 each  value pending in ROB.
REQ-016 SHALL have ports rs1_dep_out and rs2_dep_out  output  ROB_IDX_SIZE each  ROB tag of the pending producer.

Function
REQ-017 SHALL hold, for each of 32 registers: val[31:0], busy, tag[ROB_IDX_SIZE-1:0].
REQ-018 SHALL treat x0 as hardwired: reads return val 0, busy 0, dep 0; commits and renames to x0 are ignored.
REQ-019 SHALL update state only on a rising clk edge with rdy_in=1; with rdy_in=0 every register, busy and tag holds.
REQ-020 Commit: if rf_in_en and rf_dest_in!=0, val[rf_dest_in] <= rf_val_in, regardless of busy/tag.
REQ-021 Commit: busy[rf_dest_in] clears only if busy=1 and tag==rf_rob_idx_in; a stale tag leaves busy/tag unchanged.
REQ-022 Rename: if de_rename_en, de_rd_in!=0 and roll_back=0, busy[de_rd_in] <= 1 and tag[de_rd_in] <= de_rob_idx_in.
REQ-023 Same cycle, same register, commit + rename: value is written, rename wins (busy=1, tag=new index).
REQ-024 roll_back=1: all busy bits clear; tags need not be cleared; a same-cycle commit still writes its value; rename is ignored.
REQ-025 Reads SHALL be combinational, zero latency: busy_out=busy[rs], dep_out=tag[rs], val_out=val[rs].
REQ-026 Reads SHALL NOT observe a same-cycle rename (an instruction reads state before its own rename, e.g. add x1,x1,x1).
REQ-027 Both read ports SHALL be independent; rs1_in==rs2_in returns identical results on both.
REQ-028 Tag width arithmetic SHALL be exact: a tag comparison uses all ROB_IDX_SIZE bits, with no wrap handling needed.

Reset
REQ-029 rst_in=0 SHALL asynchronously set all val to 0, all busy to 0 and all tags to 0.
REQ-030 Asserting reset mid-operation SHALL discard any pending commit or rename that cycle.
REQ-031 Out of reset, every read port returns val 0, busy 0, dep 0.

Configuration
REQ-032 Macro RF_COMMIT_BYPASS_EN defined: if rf_in_en, rdy_in=1, rf_dest_in==rs!=0, busy[rs]=1 and tag[rs]==rf_rob_idx_in, then the read port returns busy_out 0 and val_out rf_val_in in the same cycle.
REQ-033 Macro RF_COMMIT_BYPASS_EN undefined: no bypass; read ports reflect registered state only, and the commit is visible the next cycle.

Verification
REQ-034 Reset, then read x0..x31 -> all val 0, busy 0, dep 0.
REQ-035 Rename x5 tag 3; next cycle read x5 -> busy 1, dep 3. Commit x5 idx 3 val 0xDEADBEEF; next cycle -> busy 0, val 0xDEADBEEF.
REQ-036 Rename x7 tag 2, then rename x7 tag 9, then commit x7 idx 2 val 0x11 -> val 0x11, busy 1, dep 9.
REQ-037 Same cycle: commit x4 idx 1 val 0x22 with roll_back=1 and rename x6 tag 5 -> next cycle x4 val 0x22, all busy 0, x6 not busy.
REQ-038 Rename x0 tag 4 and commit x0 val 0xFF -> x0 reads val 0, busy 0; rdy_in=0 during a commit x3 -> x3 unchanged.
REQ-039 With RF_COMMIT_BYPASS_EN: x8 busy tag 6, commit x8 idx 6 val 0x1234 while rs1_in=8 -> same cycle rs1_busy_out 0, rs1_val_out 0x1234; without the macro -> busy 1 until the next cycle.

Source files
------------

// File: rtl/reg_file.sv
// -----------------------------------------------------------------------------
// reg_file
// Architectural register file with rename (busy/tag) state for a ROB-based
// out-of-order core. Each of the 32 registers holds a 32-bit value, a busy bit
// and the ROB tag of its most recent in-flight producer. x0 is hardwired zero.
//
// Optional feature macro: RF_COMMIT_BYPASS_EN
//   defined   : a commit that would clear busy for a register being read is
//               forwarded to the read port in the same cycle.
//   undefined : read ports show registered state only.
//
// Ports
//   clk            in   system clock, all state on rising edge
//   rst_in         in   asynchronous active-low reset
//   rdy_in         in   pause; when low every piece of state holds
//   roll_back      in   mispredict flush, clears every busy bit
//   rf_in_en       in   commit write valid
//   rf_rob_idx_in  in   ROB index of the committing entry
//   rf_dest_in     in   architectural destination of the commit
//   rf_val_in      in   commit data
//   de_rename_en   in   decoder allocates a register-writing ROB entry
//   de_rd_in       in   destination of the dispatched instruction
//   de_rob_idx_in  in   ROB index allocated to it
//   rs1_in/rs2_in  in   source register indices
//   rsN_val_out    out  architectural value
//   rsN_busy_out   out  value still pending in the ROB
//   rsN_dep_out    out  ROB tag of the pending producer
// -----------------------------------------------------------------------------
module reg_file #(
  parameter int ROB_IDX_SIZE = 4
) (
  input  logic                    clk,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    roll_back,
  input  logic                    rf_in_en,
  input  logic [ROB_IDX_SIZE-1:0] rf_rob_idx_in,
  input  logic [4:0]              rf_dest_in,
  input  logic [31:0]             rf_val_in,
  input  logic                    de_rename_en,
  input  logic [4:0]              de_rd_in,
  input  logic [ROB_IDX_SIZE-1:0] de_rob_idx_in,
  input  logic [4:0]              rs1_in,
  input  logic [4:0]              rs2_in,
  output logic [31:0]             rs1_val_out,
  output logic [31:0]             rs2_val_out,
  output logic                    rs1_busy_out,
  output logic                    rs2_busy_out,
  output logic [ROB_IDX_SIZE-1:0] rs1_dep_out,
  output logic [ROB_IDX_SIZE-1:0] rs2_dep_out
);

  localparam int NREG = 32;

  logic [31:0]             r_val  [NREG];
  logic [NREG-1:0]         r_busy;
  logic [ROB_IDX_SIZE-1:0] r_tag  [NREG];

  logic w_commit_en;
  logic w_commit_clears;
  logic w_rename_en;

  assign w_commit_en = rf_in_en && (rf_dest_in != 5'd0);
  // A commit only retires the pending producer if it is still the newest one.
  assign w_commit_clears = w_commit_en && r_busy[rf_dest_in] &&
                           (r_tag[rf_dest_in] == rf_rob_idx_in);
  assign w_rename_en = de_rename_en && (de_rd_in != 5'd0) && !roll_back;

  // Register state: commit writes value, rename/flush manage busy and tag.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < NREG; i++) begin
        r_val[i] <= 32'd0;
        r_tag[i] <= {ROB_IDX_SIZE{1'b0}};
      end
      r_busy <= {NREG{1'b0}};
    end else if (rdy_in) begin
      if (w_commit_en) begin
        r_val[rf_dest_in] <= rf_val_in;
      end
      if (roll_back) begin
        r_busy <= {NREG{1'b0}};
      end else begin
        if (w_commit_clears) begin
          r_busy[rf_dest_in] <= 1'b0;
        end
        // Placed after the commit clear so a same-register rename wins.
        if (w_rename_en) begin
          r_busy[de_rd_in] <= 1'b1;
          r_tag[de_rd_in]  <= de_rob_idx_in;
        end
      end
    end
  end

  logic [4:0]              w_rs   [2];
  logic [31:0]             w_val  [2];
  logic                    w_busy [2];
  logic [ROB_IDX_SIZE-1:0] w_dep  [2];

  assign w_rs[0] = rs1_in;
  assign w_rs[1] = rs2_in;

  // Combinational read ports; they see state before any same-cycle rename.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_val[p]  = r_val[w_rs[p]];
      w_busy[p] = r_busy[w_rs[p]];
      w_dep[p]  = r_tag[w_rs[p]];
      if (w_rs[p] == 5'd0) begin
        w_val[p]  = 32'd0;
        w_busy[p] = 1'b0;
        w_dep[p]  = {ROB_IDX_SIZE{1'b0}};
      end else begin
`ifdef RF_COMMIT_BYPASS_EN
        if (rdy_in && w_commit_clears && (rf_dest_in == w_rs[p])) begin
          w_val[p]  = rf_val_in;
          w_busy[p] = 1'b0;
        end else begin
          w_busy[p] = r_busy[w_rs[p]];
        end
`else
        w_busy[p] = r_busy[w_rs[p]];
`endif
      end
    end
  end

  assign rs1_val_out  = w_val[0];
  assign rs2_val_out  = w_val[1];
  assign rs1_busy_out = w_busy[0];
  assign rs2_busy_out = w_busy[1];
  assign rs1_dep_out  = w_dep[0];
  assign rs2_dep_out  = w_dep[1];

endmodule
